// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/handshake bundle between the control FSM and seq_multiplier.
interface seq_mult_if #(parameter int WIDTH = 8);
  logic               load_data;
  logic               mult_active;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               load_done;
  logic               mult_done;
  logic               busy;
  logic [2*WIDTH-1:0] product;
  modport master(output load_data, mult_active, a_in, b_in,
                 input load_done, mult_done, busy, product);
  modport slave(input load_data, mult_active, a_in, b_in,
                output load_done, mult_done, busy, product);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: fixed-latency shift-add unsigned multiplier, one iteration per clock.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst,
   input logic       clr,
   seq_mult_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, LOADED, CALC, DONE} state_t;
   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] a_q, a_d, acc_q, acc_d, prod_q, prod_d, add;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end
   assign add = b_q[0] ? acc_q + a_q : acc_q;
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      if (clr) begin
         state_d = IDLE;
         a_d     = '0;
         b_d     = '0;
         acc_d   = '0;
         cnt_d   = '0;
         prod_d  = '0;
      end else begin
         case (state_q)
            IDLE, DONE, LOADED: begin
               if (bus.load_data) begin
                  state_d = LOADED;
                  a_d     = {{WIDTH{1'b0}}, bus.a_in};
                  b_d     = bus.b_in;
                  acc_d   = '0;
               end else if (state_q == LOADED && bus.mult_active) begin
                  state_d = CALC;
                  cnt_d   = '0;
               end
            end
            CALC: begin
               // Dropping mult_active aborts without touching product.
               if (!bus.mult_active) state_d = IDLE;
               else begin
                  acc_d = add;
                  a_d   = a_q << 1;
                  b_d   = b_q >> 1;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CW'(WIDTH - 1)) begin
                     prod_d  = add;
                     state_d = DONE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
   assign bus.load_done = (state_q == LOADED);
   assign bus.mult_done = (state_q == DONE);
   assign bus.busy      = (state_q == CALC);
   assign bus.product   = prod_q;
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width (unsigned); product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 clr  input  1  synchronous clear, active-high; same effect as reset, applied on the clock edge.
REQ-005 load_data  input  1  level request from the control FSM to capture operands.
REQ-006 mult_active  input  1  level request from the control FSM to run the multiply.
REQ-007 a_in  input  WIDTH  multiplicand, sampled only on the capture edge.
REQ-008 b_in  input  WIDTH  multiplier, sampled only on the capture edge.
REQ-009 load_done  output  1  operands captured; registered level.
REQ-010 mult_done  output  1  product valid; registered level.
REQ-011 busy  output  1  multiply iteration in progress.
REQ-012 product  output  2*WIDTH  last completed unsigned product, registered.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOADED, CALC and DONE.
REQ-014 IDLE: load_data=1 -> capture a_in/b_in into internal registers, clear the accumulator, go to LOADED; otherwise stay in IDLE.
REQ-015 LOADED: load_done=1 for every cycle in this state.
REQ-016 LOADED transitions: load_data=1 -> recapture operands and stay in LOADED; else mult_active=1 -> go to CALC with iteration count 0; else hold.
REQ-017 Priority: load_data SHALL win over mult_active when both are high in LOADED, IDLE or DONE.
REQ-018 CALC: each edge performs one shift-add iteration.
  - If multiplier LSB=1, add the shifted multiplicand into the 2*WIDTH accumulator.
  - Shift the multiplier right by 1 and the multiplicand left by 1.
  - Increment the count.
  - No overflow is possible; the full 2*WIDTH width is kept.
REQ-019 Latency: mult_done SHALL go high on the WIDTH-th edge after the edge that sampled mult_active=1 in LOADED (8 edges at WIDTH=8), with a fixed latency and no early exit on zero operands.
REQ-020 On the final iteration the FSM SHALL load product with the completed accumulator and enter DONE in the same edge.
REQ-021 Abort: if mult_active=0 on any CALC edge, the FSM SHALL go to IDLE, leave product unchanged and never assert mult_done.
REQ-022 busy SHALL be 1 exactly while in CALC, and load_done SHALL be 0 outside LOADED.
REQ-023 DONE: mult_done=1 is held until load_data=1, which captures new operands and moves to LOADED (mult_done drops on that edge); mult_active is ignored in DONE.
REQ-024 product SHALL change only on entering DONE or on reset/clr, and SHALL hold across LOADED/CALC of a subsequent operation.
REQ-025 a_in/b_in changes outside a capture edge SHALL have no effect on the result.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) force: state IDLE, load_done=0, mult_done=0, busy=0, product=0, operand/accumulator/count registers=0.
REQ-027 Reset release SHALL be synchronous-safe: the first state change occurs no earlier than the first rising edge after rst returns high.
REQ-028 clr=1 at an edge SHALL produce the same register values as REQ-026 and override all other inputs; rst asserted mid-CALC SHALL abort with product=0.

Verification
REQ-029 WIDTH=8, a=13, b=11: load_data 1 cycle -> load_done=1 next cycle; mult_active held -> mult_done after exactly 8 edges, product=0x008F, busy high 8 cycles.
REQ-030 a=255, b=255 -> product=0xFE01; then a=0, b=200 -> product=0x0000 with the same 8-edge latency.
REQ-031 Drop mult_active after 4 CALC edges with the prior product=0x008F -> FSM returns to IDLE, mult_done stays 0, product stays 0x008F.
REQ-032 load_data and mult_active both high in LOADED -> operands recaptured, still in LOADED, busy=0.
REQ-033 rst=0 pulse mid-CALC (not aligned to clk) -> all outputs 0 immediately; a clr=1 edge in DONE -> IDLE, product=0.
REQ-034 Back-to-back: from DONE, load_data with a=3, b=5 -> mult_done falls on the capture edge, new product=0x000F after 8 more edges.
